instr_fetch_issue: RTL

- Front-end sequencer that produces the decode fields (instruction_type, func, imm, vector) consumed by the control unit, and resolves the jump controls (JumpI, JumpCI, JumpCD) that the control unit returns.
- Fetches 32-bit words from instruction memory over a req/valid interface.
- Presents each word under a valid/ready handshake.
- Holds on control-type instructions until their jump outcome is resolved.

---
 rtl/instr_fetch_issue.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_issue.sv
// ---------------------------------------------------------------------------
// instr_fetch_issue
//
// Front-end sequencer. It fetches 32-bit words from instruction memory, holds
// each word in the instruction register (IR) and offers the decode fields
// downstream under a valid/ready handshake. Control-type instructions
// (type 00) park the sequencer until the control unit returns the jump
// outcome. A type-11 word halts the sequencer; only rst leaves HALT.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start               begin fetching from RESET_PC (IDLE only)
//   imem_req/addr       one-cycle fetch request and its word address
//   imem_valid/rdata    returned instruction word
//   issue_valid/ready   issue handshake for the current IR
//   instr_word          IR; instruction_type/func/imm/vector decode from it
//   resolve_valid       jump controls valid (looked at only in WAIT_BR)
//   JumpI/JumpCI/JumpCD jump controls; cond_flag is the datapath equality flag
//   br_target           jump target address
//   pc                  address of the current instruction
//   halted              halt reached
//   instr_count         number of accepted issues (wraps)
//
// State table
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | waiting for start
//   REQ      | imem_req high for this single cycle, imem_addr = pc
//   WAIT_MEM | waiting for imem_valid; the word is captured into IR
//   ISSUE    | issue_valid high, IR held until issue_ready
//   WAIT_BR  | control instruction accepted, waiting for resolve_valid
//   HALT     | halt word fetched; everything idle until rst
// ---------------------------------------------------------------------------
module instr_fetch_issue #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PC_STEP  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,

    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [31:0]       imem_rdata,

    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [31:0]       instr_word,
    output logic [1:0]        instruction_type,
    output logic [1:0]        func,
    output logic              imm,
    output logic              vector,

    input  logic              resolve_valid,
    input  logic              JumpI,
    input  logic              JumpCI,
    input  logic              JumpCD,
    input  logic              cond_flag,
    input  logic [ADDR_W-1:0] br_target,

    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [31:0]       instr_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_WAIT_MEM = 3'd2,
        S_ISSUE    = 3'd3,
        S_WAIT_BR  = 3'd4,
        S_HALT     = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
    localparam logic [1:0]        TYPE_CTRL = 2'b00;
    localparam logic [1:0]        TYPE_HALT = 2'b11;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [31:0]         ir_q, ir_d;
    logic [31:0]         count_q, count_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                issue_valid_q, issue_valid_d;
    logic                halted_q, halted_d;

    logic [ADDR_W-1:0]   pc_seq;
    logic [ADDR_W-1:0]   pc_jump;
    logic                taken;
    logic                handshake;

    // Sequential successor wraps naturally at 2^ADDR_W.
    assign pc_seq    = pc_q + STEP;
    // Several asserted controls simply OR together.
    assign taken     = JumpI | (JumpCI & cond_flag) | (JumpCD & ~cond_flag);
    assign pc_jump   = taken ? br_target : pc_seq;
    assign handshake = issue_valid_q & issue_ready;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        count_d       = count_q;
        // The request strobe and its address are only ever set on the
        // transition into REQ, so they last exactly one cycle.
        req_d         = 1'b0;
        addr_d        = '0;
        issue_valid_d = issue_valid_q;
        halted_d      = halted_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = START_PC;
                    req_d   = 1'b1;
                    addr_d  = START_PC;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                // Any imem_valid here is too early to belong to this request.
                state_d = S_WAIT_MEM;
            end

            S_WAIT_MEM: begin
                if (imem_valid) begin
                    ir_d = imem_rdata;
                    if (imem_rdata[31:30] == TYPE_HALT) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        issue_valid_d = 1'b1;
                        state_d       = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                if (handshake) begin
                    count_d       = count_q + 32'd1;
                    issue_valid_d = 1'b0;
                    if (ir_q[31:30] == TYPE_CTRL) begin
                        state_d = S_WAIT_BR;
                    end else begin
                        pc_d    = pc_seq;
                        req_d   = 1'b1;
                        addr_d  = pc_seq;
                        state_d = S_REQ;
                    end
                end
            end

            S_WAIT_BR: begin
                if (resolve_valid) begin
                    pc_d    = pc_jump;
                    req_d   = 1'b1;
                    addr_d  = pc_jump;
                    state_d = S_REQ;
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= START_PC;
            ir_q          <= '0;
            count_q       <= '0;
            req_q         <= 1'b0;
            addr_q        <= '0;
            issue_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            count_q       <= count_d;
            req_q         <= req_d;
            addr_q        <= addr_d;
            issue_valid_q <= issue_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign imem_req         = req_q;
    assign imem_addr        = addr_q;
    assign issue_valid      = issue_valid_q;
    assign instr_word       = ir_q;
    assign instruction_type = ir_q[31:30];
    assign func             = ir_q[29:28];
    assign imm              = ir_q[27];
    assign vector           = ir_q[26];
    assign pc               = pc_q;
    assign halted           = halted_q;
    assign instr_count      = count_q;

endmodule
